seq_mul32: RTL
==============

SEQ_MUL32 -- requirements
Module: seq_mul32

Interface
REQ-001 Parameters: none; operand width fixed at 32, product width fixed at 64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 A  input  32  multiplicand, unsigned; captured on accepted start.
REQ-006 B  input  32  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while a multiply is iterating (RUN state).
REQ-008 done  output  1  one-cycle pulse marking a valid new product.
REQ-009 product  output  64  registered unsigned result A*B; held between operations.

Function
REQ-010 The block SHALL compute unsigned A*B by radix-2 shift-add, one iteration per clk cycle, using the team's 32-bit ripple adder (Adder32) for every partial-sum addition.
REQ-011 The block SHALL have state registers: FSM state, mcand[31:0], hi[31:0], lo[31:0], cnt[4:0], product[63:0].
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE with start=1 SHALL load mcand<=A, lo<=B, hi<=0, cnt<=0 and go to RUN; IDLE with start=0 SHALL stay in IDLE.
REQ-014 In RUN, each cycle SHALL form {c,s} = hi + (lo[0] ? mcand : 0) via Adder32 (c = adder carry-out), then load {hi,lo} <= {c,s,lo} >> 1, i.e. hi<={c,s[31:1]}, lo<={s[0],lo[31:1]}.
REQ-015 In RUN, cnt SHALL increment each cycle; the iteration with cnt==31 SHALL be the last, and the FSM SHALL then go to DONE.
REQ-016 On the RUN->DONE transition edge, product SHALL load the final {hi,lo} value, computed from the same iteration's shift.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both are decoded from registered state.
REQ-019 Latency: start accepted at edge E -> busy high for cycles E+1..E+32 -> done high in cycle E+33 with product valid from that cycle onward.
REQ-020 Throughput: a new start is accepted no earlier than the IDLE cycle following DONE, giving a 34-cycle minimum issue interval.
REQ-021 start asserted in RUN or DONE SHALL be ignored; A and B changes after acceptance SHALL have no effect on the result.
REQ-022 product SHALL change only on the RUN->DONE edge or on reset; during RUN it SHALL hold the previous result.
REQ-023 The result SHALL be exact for all inputs; the carry from Adder32 SHALL never be dropped (max 0xFFFFFFFE00000001).
REQ-024 Operand value zero SHALL NOT shorten the operation; latency is data-independent.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, busy=0, done=0, product=0, hi=0, lo=0, mcand=0, cnt=0, regardless of current state.
REQ-026 Reset asserted in RUN SHALL abort the multiply with no done pulse; no partial result SHALL appear on product.
REQ-027 start asserted together with rst SHALL be ignored; the first accepted start is the first edge with rst=0 and start=1 in IDLE.

Verification
REQ-028 A=3, B=5, start pulse -> busy for 32 cycles, done in cycle 33 after acceptance, product=0x000000000000000F.
REQ-029 A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0xFFFFFFFE00000001 (exercises adder carry each iteration).
REQ-030 A=0x12345678, B=0 then A=0, B=0x9ABCDEF0 -> product=0 both times, same 33-cycle latency.
REQ-031 Start A=7,B=6; at cycle 10 of RUN assert start with A=1,B=1 -> ignored, product=42, single done pulse.
REQ-032 Start A=0x10000,B=0x10000; assert rst at cycle 15 of RUN -> busy=0, done never pulses, product=0; next start A=2,B=9 -> product=18.
REQ-033 Back-to-back: start held high continuously with A=0x80000000,B=2 -> accepted every 34 cycles, each done shows product=0x0000000100000000.

Source files
------------

// File: rtl/seq_mul32.sv
// Unsigned 32x32 -> 64 radix-2 shift-add multiplier: one partial-sum add per cycle
// through a ripple-carry Adder32, 32 iterations, then a one-cycle done pulse.

module Adder32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout
);

   logic [32:0] w_carry;

   assign w_carry[0] = i_cin;

   for (genvar g = 0; g < 32; g++) begin : g_fa
      assign o_sum[g]       = i_a[g] ^ i_b[g] ^ w_carry[g];
      assign w_carry[g + 1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_carry[32];

endmodule

// Handshake: start is taken only in IDLE; busy marks RUN, done is a one-cycle pulse
// in DONE, and product stays stable until the next RUN->DONE edge or reset.
module seq_mul32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [1:0]  o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_mcand;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [4:0]  r_cnt;
   logic [63:0] r_product;

   logic [31:0] w_addend;
   logic [31:0] w_sum;
   logic        w_cout;
   logic        w_load;
   logic        w_last;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;

   assign w_addend = r_lo[0] ? r_mcand : 32'd0;

   Adder32 u_adder (
      .i_a    (r_hi),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // Shift the 65-bit {carry, sum, lo} right by one so the carry is never lost.
   assign w_hi_nxt = {w_cout, w_sum[31:1]};
   assign w_lo_nxt = {w_sum[0], r_lo[31:1]};

   assign w_load = (r_state == S_IDLE) && start;
   assign w_last = (r_state == S_RUN) && (r_cnt == 5'd31);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_cnt == 5'd31) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_mcand   <= 32'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_cnt     <= 5'd0;
         r_product <= 64'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_mcand <= A;
            r_lo    <= B;
            r_hi    <= 32'd0;
            r_cnt   <= 5'd0;
         end else if (r_state == S_RUN) begin
            r_hi  <= w_hi_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt + 5'd1;
         end
         if (w_last) begin
            r_product <= {w_hi_nxt, w_lo_nxt};
         end
      end
   end

   assign busy        = (r_state == S_RUN);
   assign done        = (r_state == S_DONE);
   assign product     = r_product;
   assign o_dbg_state = r_state;

endmodule
